// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared types, constants and sizing helpers for the mem_dp_bank RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int WR_FIRST = 0;
  localparam int RD_FIRST = 1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // Never returns less than 1 so a single-word bank still gets a 1-bit address.
  function automatic int CLOG2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int NB_OF(input int width, input int byte_w);
    return width / byte_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_rd_pipe.sv
// ============================================================================
// mem_rd_pipe : per-port read-data/valid pipeline, RD_LAT = 1 or 2 stages.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_rd_pipe #(
  parameter int WIDTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic             s1_vld_q;
  logic [WIDTH-1:0] s1_data_q;

  // Data stages only load on a valid beat so the output holds between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q <= vld_i;
      if (vld_i) s1_data_q <= data_i;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic             s2_vld_q;
      logic [WIDTH-1:0] s2_data_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_vld_q  <= 1'b0;
          s2_data_q <= '0;
        end else begin
          s2_vld_q <= s1_vld_q;
          if (s1_vld_q) s2_data_q <= s1_data_q;
        end
      end

      assign vld_o  = s2_vld_q;
      assign data_o = s2_data_q;
    end else begin : g_lat1
      assign vld_o  = s1_vld_q;
      assign data_o = s1_data_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_dp_bank.sv
// ============================================================================
// mem_dp_bank : true-dual-port byte-enabled RAM bank with hardware clear sweep.
// Optional per-byte even parity with a_perr/b_perr outputs: define MEM_PARITY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_dp_bank
  import mem_pkg::*;
#(
  parameter  int WIDTH   = 64,
  parameter  int DEPTH   = 32,
  parameter  int BYTE_W  = 8,
  parameter  int RD_LAT  = 1,
  parameter  int WR_MODE = WR_FIRST,
  localparam int NB      = NB_OF(WIDTH, BYTE_W),
  localparam int AW      = CLOG2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_req,
  output logic             busy,
  input  logic             a_en,
  input  logic [NB-1:0]    a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_di,
  output logic [WIDTH-1:0] a_do,
  output logic             a_vld,
  input  logic             b_en,
  input  logic [NB-1:0]    b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_di,
  output logic [WIDTH-1:0] b_do,
  output logic             b_vld,
  output logic             coll
`ifdef MEM_PARITY_EN
  ,
  output logic [NB-1:0]    a_perr,
  output logic [NB-1:0]    b_perr
`endif
);

`ifdef MEM_PARITY_EN
  localparam int MW = WIDTH + NB;
`else
  localparam int MW = WIDTH;
`endif
  localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_w,
                                             input logic [WIDTH-1:0] new_w,
                                             input logic [NB-1:0]    we);
    logic [WIDTH-1:0] r;
    r = old_w;
    for (int k = 0; k < NB; k++)
      if (we[k]) r[k*BYTE_W +: BYTE_W] = new_w[k*BYTE_W +: BYTE_W];
    return r;
  endfunction

  logic [MW-1:0]    mem_q [DEPTH];
  clr_state_e       state_q;
  logic [AW-1:0]    cnt_q;
  logic             busy_q;
  logic             coll_q;

  logic             a_acc, b_acc, a_inr, b_inr, a_wr, b_wr, same_addr;
  logic [MW-1:0]    a_raw, b_raw;
  logic [WIDTH-1:0] a_post, b_post, a_rd, b_rd;
  logic [MW-1:0]    a_pin, b_pin, a_pout, b_pout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          if (cnt_q == c_LAST) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        READY: begin
          if (clr_req) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign a_acc     = a_en && !busy_q;
  assign b_acc     = b_en && !busy_q;
  assign a_inr     = {1'b0, a_addr} < c_DEPTH;
  assign b_inr     = {1'b0, b_addr} < c_DEPTH;
  assign a_wr      = a_acc && a_inr && (|a_we);
  assign b_wr      = b_acc && b_inr && (|b_we);
  assign same_addr = (a_addr == b_addr);

  assign a_raw = a_inr ? mem_q[a_addr] : '0;
  assign b_raw = b_inr ? mem_q[b_addr] : '0;

  // Post-write word as it will actually land: B's bytes first, A's on top.
  assign a_post = merge(merge(a_raw[WIDTH-1:0], b_di, (b_wr && same_addr) ? b_we : '0),
                        a_di, a_we);
  assign b_post = merge(merge(b_raw[WIDTH-1:0], b_di, b_we),
                        a_di, (a_wr && same_addr) ? a_we : '0);

  assign a_rd = (WR_MODE == RD_FIRST || !a_wr) ? a_raw[WIDTH-1:0] : a_post;
  assign b_rd = (WR_MODE == RD_FIRST || !b_wr) ? b_raw[WIDTH-1:0] : b_post;

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (b_wr) begin
        for (int k = 0; k < NB; k++) begin
          if (b_we[k]) begin
            mem_q[b_addr][k*BYTE_W +: BYTE_W] <= b_di[k*BYTE_W +: BYTE_W];
`ifdef MEM_PARITY_EN
            mem_q[b_addr][WIDTH+k] <= ^b_di[k*BYTE_W +: BYTE_W];
`endif
          end
        end
      end
      if (a_wr) begin
        for (int k = 0; k < NB; k++) begin
          if (a_we[k]) begin
            mem_q[a_addr][k*BYTE_W +: BYTE_W] <= a_di[k*BYTE_W +: BYTE_W];
`ifdef MEM_PARITY_EN
            mem_q[a_addr][WIDTH+k] <= ^a_di[k*BYTE_W +: BYTE_W];
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) coll_q <= 1'b0;
    else     coll_q <= a_wr && b_wr && same_addr;
  end

  assign busy = busy_q;
  assign coll = coll_q;

`ifdef MEM_PARITY_EN
  logic [NB-1:0] a_pchk, b_pchk;

  // Bytes returned as freshly written data in write-first mode are not checked.
  for (genvar k = 0; k < NB; k++) begin : g_par
    assign a_pchk[k] = ((^a_raw[k*BYTE_W +: BYTE_W]) ^ a_raw[WIDTH+k])
                       & ~((WR_MODE == WR_FIRST) && a_wr && a_we[k]);
    assign b_pchk[k] = ((^b_raw[k*BYTE_W +: BYTE_W]) ^ b_raw[WIDTH+k])
                       & ~((WR_MODE == WR_FIRST) && b_wr && b_we[k]);
  end

  assign a_pin  = {a_pchk, a_rd};
  assign b_pin  = {b_pchk, b_rd};
  assign a_do   = a_pout[WIDTH-1:0];
  assign b_do   = b_pout[WIDTH-1:0];
  assign a_perr = a_pout[MW-1:WIDTH];
  assign b_perr = b_pout[MW-1:WIDTH];
`else
  assign a_pin = a_rd;
  assign b_pin = b_rd;
  assign a_do  = a_pout;
  assign b_do  = b_pout;
`endif

  mem_rd_pipe #(
    .WIDTH  (MW),
    .RD_LAT (RD_LAT)
  ) u_pipe_a (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (a_acc),
    .data_i (a_pin),
    .vld_o  (a_vld),
    .data_o (a_pout)
  );

  mem_rd_pipe #(
    .WIDTH  (MW),
    .RD_LAT (RD_LAT)
  ) u_pipe_b (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (b_acc),
    .data_i (b_pin),
    .vld_o  (b_vld),
    .data_o (b_pout)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_dp_bank.sv
// ============================================================================
// tb_mem_dp_bank : scoreboard bench driving three mem_dp_bank builds in lockstep
// (write-first/lat1, read-first/lat1, write-first/lat2). Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_dp_bank;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, clr_req, a_en, b_en;
  logic [3:0]  a_we, b_we, a_addr, b_addr;
  logic [31:0] a_di, b_di;

  logic [31:0] a_do0, a_do1, a_do2, b_do0, b_do1, b_do2;
  logic        a_vld0, a_vld1, a_vld2, b_vld0, b_vld1, b_vld2;
  logic        busy0, busy1, busy2, coll0, coll1, coll2;
`ifdef MEM_PARITY_EN
  logic [3:0]  a_perr0, a_perr1, a_perr2, b_perr0, b_perr1, b_perr2;
`endif

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic [31:0] mdl [16];
  exp_t        sb [6][$];

  always #5 clk = ~clk;

  mem_dp_bank #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .RD_LAT(1), .WR_MODE(0)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_di(a_di), .a_do(a_do0), .a_vld(a_vld0),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_di(b_di), .b_do(b_do0), .b_vld(b_vld0),
    .coll(coll0)
`ifdef MEM_PARITY_EN
    , .a_perr(a_perr0), .b_perr(b_perr0)
`endif
  );

  mem_dp_bank #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .RD_LAT(1), .WR_MODE(1)) dut_rf (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_di(a_di), .a_do(a_do1), .a_vld(a_vld1),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_di(b_di), .b_do(b_do1), .b_vld(b_vld1),
    .coll(coll1)
`ifdef MEM_PARITY_EN
    , .a_perr(a_perr1), .b_perr(b_perr1)
`endif
  );

  mem_dp_bank #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .RD_LAT(2), .WR_MODE(0)) dut_l2 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy2),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_di(a_di), .a_do(a_do2), .a_vld(a_vld2),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_di(b_di), .b_do(b_do2), .b_vld(b_vld2),
    .coll(coll2)
`ifdef MEM_PARITY_EN
    , .a_perr(a_perr2), .b_perr(b_perr2)
`endif
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (we[k]) r[k*8 +: 8] = n[k*8 +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pops scoreboard entries whose strobe is due and flags overdue ones.
  task automatic mon();
    logic [5:0]  v;
    logic [31:0] d [6];
    exp_t        e;
    v = {b_vld2, b_vld1, b_vld0, a_vld2, a_vld1, a_vld0};
    d[0] = a_do0; d[1] = a_do1; d[2] = a_do2;
    d[3] = b_do0; d[4] = b_do1; d[5] = b_do2;
    for (int p = 0; p < 6; p++) begin
      if (v[p]) begin
        check($sformatf("vld_expected[%0d]", p), 64'(sb[p].size() != 0), 64'(1));
        if (sb[p].size() != 0) begin
          e = sb[p].pop_front();
          check($sformatf("rdata[%0d]", p), 64'(d[p]), 64'(e.d));
          check($sformatf("latency[%0d]", p), 64'(cyc), 64'(e.c));
        end
      end
      while (sb[p].size() != 0 && sb[p][0].c < cyc) begin
        e = sb[p].pop_front();
        check($sformatf("vld_missing[%0d]", p), 64'(cyc), 64'(e.c));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    a_en = 1'b0;
    b_en = 1'b0;
    repeat (n) tick();
  endtask

  // One cycle of accepted port traffic; expectations derived from the model.
  task automatic drive(input logic ae, input logic [3:0] awe, input logic [3:0] aad,
                       input logic [31:0] adi,
                       input logic be, input logic [3:0] bwe, input logic [3:0] bad,
                       input logic [31:0] bdi);
    logic [31:0] olda, oldb, newa, newb;
    a_en = ae; a_we = awe; a_addr = aad; a_di = adi;
    b_en = be; b_we = bwe; b_addr = bad; b_di = bdi;
    olda = mdl[aad];
    oldb = mdl[bad];
    if (be && bwe != 4'h0) mdl[bad] = merge(mdl[bad], bdi, bwe);
    if (ae && awe != 4'h0) mdl[aad] = merge(mdl[aad], adi, awe);
    newa = mdl[aad];
    newb = mdl[bad];
    if (ae) begin
      sb[0].push_back('{(awe != 4'h0) ? newa : olda, cyc + 1});
      sb[1].push_back('{olda, cyc + 1});
      sb[2].push_back('{(awe != 4'h0) ? newa : olda, cyc + 2});
    end
    if (be) begin
      sb[3].push_back('{(bwe != 4'h0) ? newb : oldb, cyc + 1});
      sb[4].push_back('{oldb, cyc + 1});
      sb[5].push_back('{(bwe != 4'h0) ? newb : oldb, cyc + 2});
    end
    tick();
  endtask

  task automatic busy_window(input string tag, input int pulse_at);
    for (int i = 0; i < 16; i++) begin
      check(tag, 64'({busy0, busy1, busy2}), 64'(3'b111));
      clr_req = (i == pulse_at);
      tick();
    end
    clr_req = 1'b0;
    check({tag, "_end"}, 64'({busy0, busy1, busy2}), 64'(3'b000));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr_req = 1'b0;
    a_en = 1'b0; a_we = '0; a_addr = '0; a_di = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_di = '0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    repeat (3) tick();

    check("rst_busy", 64'({busy0, busy1, busy2}), 64'(3'b111));
    check("rst_vld", 64'({a_vld0, a_vld1, a_vld2, b_vld0, b_vld1, b_vld2}), 64'(0));
    check("rst_do", 64'(a_do0 | a_do1 | a_do2 | b_do0 | b_do1 | b_do2), 64'(0));
    check("rst_coll", 64'({coll0, coll1, coll2}), 64'(0));

    // Sweep after reset; a read of addr 5 mid-sweep must be dropped.
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("busy_after_rst", 64'({busy0, busy1, busy2}), 64'(3'b111));
      a_en = (i == 3); a_we = '0; a_addr = 4'd5;
      tick();
    end
    a_en = 1'b0;
    check("busy_after_rst_end", 64'({busy0, busy1, busy2}), 64'(3'b000));

    for (int i = 0; i < 16; i++) drive(1, 4'h0, 4'(i), '0, 1, 4'h0, 4'(15 - i), '0);
    idle(3);

    drive(1, 4'hF, 4'd3, 32'hDEADBEEF, 0, 4'h0, 4'd0, '0);
    drive(1, 4'b0101, 4'd3, 32'h11223344, 0, 4'h0, 4'd0, '0);
    drive(0, 4'h0, 4'd0, '0, 1, 4'h0, 4'd3, '0);
    idle(3);
    check("byte_merge_b", 64'(b_do0), 64'(32'hDE22BE44));
    check("byte_merge_b_rf", 64'(b_do1), 64'(32'hDE22BE44));

    drive(1, 4'hF, 4'd7, 32'hAAAA5555, 0, 4'h0, 4'd0, '0);
    drive(1, 4'hF, 4'd7, 32'h12345678, 0, 4'h0, 4'd0, '0);
    idle(3);
    check("write_first", 64'(a_do0), 64'(32'h12345678));
    check("read_first", 64'(a_do1), 64'(32'hAAAA5555));
    check("write_first_l2", 64'(a_do2), 64'(32'h12345678));

    drive(1, 4'h1, 4'd9, 32'h000000FF, 1, 4'hF, 4'd9, 32'hFFFFFF00);
    check("coll_pulse", 64'({coll0, coll1, coll2}), 64'(3'b111));
    idle(1);
    check("coll_clear", 64'({coll0, coll1, coll2}), 64'(3'b000));
    drive(1, 4'h0, 4'd9, '0, 0, 4'h0, 4'd0, '0);
    idle(3);
    check("coll_merge", 64'(a_do0), 64'(32'hFFFFFFFF));

    drive(1, 4'hF, 4'd4, 32'h0BADF00D, 1, 4'h0, 4'd4, '0);
    idle(3);
    check("xport_old_wf", 64'(b_do0), 64'(0));
    check("xport_old_rf", 64'(b_do1), 64'(0));

    drive(1, 4'hF, 4'd1, 32'h01010101, 1, 4'hF, 4'd2, 32'h02020202);
    drive(1, 4'h0, 4'd1, '0, 0, 4'h0, 4'd0, '0);
    drive(1, 4'h0, 4'd2, '0, 0, 4'h0, 4'd0, '0);
    drive(1, 4'h0, 4'd3, '0, 0, 4'h0, 4'd0, '0);
    idle(4);
    check("lat2_last", 64'(a_do2), 64'(32'hDE22BE44));

    // Requested sweep; a second request mid-sweep must not extend it.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_window("busy_clr_req", 5);
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    drive(1, 4'h0, 4'd1, '0, 0, 4'h0, 4'd0, '0);
    idle(3);
    check("cleared_wf", 64'(a_do0), 64'(0));
    check("cleared_l2", 64'(a_do2), 64'(0));

    // Reset eight cycles into a sweep restarts it from the beginning.
    drive(1, 4'hF, 4'd15, 32'hCAFEF00D, 1, 4'hF, 4'd1, 32'h55555555);
    idle(2);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_window("busy_rst_restart", -1);
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    drive(1, 4'h0, 4'd15, '0, 1, 4'h0, 4'd1, '0);
    idle(3);
    check("restart_cleared_a", 64'(a_do0), 64'(0));
    check("restart_cleared_b", 64'(b_do0), 64'(0));

`ifdef MEM_PARITY_EN
    drive(1, 4'hF, 4'd6, 32'h12345678, 0, 4'h0, 4'd0, '0);
    idle(2);
    dut.mem_q[6][16] = ~dut.mem_q[6][16];
    mdl[6][16] = ~mdl[6][16];
    drive(1, 4'h0, 4'd6, '0, 0, 4'h0, 4'd0, '0);
    check("parity_err", 64'(a_perr0), 64'(4'b0100));
    idle(3);
`endif

    idle(4);
    for (int p = 0; p < 6; p++)
      check($sformatf("sb_drained[%0d]", p), 64'(sb[p].size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
